// File: rtl/iob_plic_claim_master.sv
// Claim/complete sequencer for iob_plic targets: claims over an IOb master port,
// hands the source ID to the core, then writes it back on completion.
module iob_plic_claim_master #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int SOURCES = 8,
   parameter int TARGETS = 2,
   parameter logic [ADDR_W-1:0] CLAIM_BASE = 16'h0200,
   parameter logic [ADDR_W-1:0] CLAIM_STRIDE = 16'h0008,
   localparam int ID_W = $clog2(SOURCES + 1),
   localparam int TGT_W = (TARGETS > 1) ? $clog2(TARGETS) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [TARGETS-1:0]    meip,
   output logic                  iob_avalid,
   output logic [ADDR_W-1:0]     iob_addr,
   output logic [DATA_W-1:0]     iob_wdata,
   output logic [DATA_W/8-1:0]   iob_wstrb,
   input  logic                  iob_ready,
   input  logic                  iob_rvalid,
   input  logic [DATA_W-1:0]     iob_rdata,
   output logic                  irq_valid,
   output logic [TGT_W-1:0]      irq_target,
   output logic [ID_W-1:0]       irq_id,
   input  logic                  irq_ready,
   input  logic                  irq_done,
   output logic                  busy,
   output logic [7:0]            spurious_cnt
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      PRESENT = 3'd3,
      SERVICE = 3'd4,
      WR_REQ  = 3'd5
   } state_t;

   // First requesting target strictly after last, wrapping modulo TARGETS.
   function automatic logic [TGT_W-1:0] rr_pick(input logic [TARGETS-1:0] req,
                                                input logic [TGT_W-1:0] last);
      logic [TGT_W-1:0] pick;
      logic             found;
      int               idx;
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= TARGETS; i++) begin
         idx = (int'(last) + i) % TARGETS;
         if (!found && req[idx[TGT_W-1:0]]) begin
            pick  = idx[TGT_W-1:0];
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [ADDR_W-1:0] claim_addr(input logic [TGT_W-1:0] tgt);
      return CLAIM_BASE + ADDR_W'(tgt) * CLAIM_STRIDE;
   endfunction

   state_t               state_r, state_s;
   logic [TGT_W-1:0]     cur_tgt_r, cur_tgt_s;
   logic [TGT_W-1:0]     last_tgt_r, last_tgt_s;
   logic [ID_W-1:0]      id_r, id_s;
   logic [7:0]           spur_r, spur_s;
   logic                 rd_fin_s;
   logic [ID_W-1:0]      rd_id_s;
   logic                 avalid_r, avalid_s;
   logic [ADDR_W-1:0]    addr_r, addr_s;
   logic [DATA_W-1:0]    wdata_r, wdata_s;
   logic [DATA_W/8-1:0]  wstrb_r, wstrb_s;
   logic                 irq_valid_r, irq_valid_s;
   logic [TGT_W-1:0]     irq_target_r, irq_target_s;
   logic [ID_W-1:0]      irq_id_r, irq_id_s;
   logic                 busy_r, busy_s;
   logic                 rdata_unused_s;

   assign rdata_unused_s = ^iob_rdata[DATA_W-1:ID_W];
   assign rd_id_s        = iob_rdata[ID_W-1:0];

   // Next-state logic; outputs are computed from the next state so they register in step.
   always_comb begin
      state_s    = state_r;
      cur_tgt_s  = cur_tgt_r;
      last_tgt_s = last_tgt_r;
      id_s       = id_r;
      spur_s     = spur_r;
      rd_fin_s   = 1'b0;

      case (state_r)
         IDLE: begin
            if (|meip) begin
               cur_tgt_s = rr_pick(meip, last_tgt_r);
               state_s   = RD_REQ;
            end else begin
               state_s = IDLE;
            end
         end
         RD_REQ: begin
            if (iob_ready && iob_rvalid) begin
               rd_fin_s = 1'b1;
            end else if (iob_ready) begin
               state_s = RD_WAIT;
            end else begin
               state_s = RD_REQ;
            end
         end
         RD_WAIT: begin
            if (iob_rvalid) begin
               rd_fin_s = 1'b1;
            end else begin
               state_s = RD_WAIT;
            end
         end
         PRESENT: begin
            if (irq_ready) begin
               state_s = SERVICE;
            end else begin
               state_s = PRESENT;
            end
         end
         SERVICE: begin
            if (irq_done) begin
               state_s = WR_REQ;
            end else begin
               state_s = SERVICE;
            end
         end
         WR_REQ: begin
            if (iob_ready) begin
               last_tgt_s = cur_tgt_r;
               state_s    = IDLE;
            end else begin
               state_s = WR_REQ;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      // ID 0 means nothing was pending: count it and skip the complete write.
      if (rd_fin_s) begin
         id_s = rd_id_s;
         if (rd_id_s == {ID_W{1'b0}}) begin
            spur_s     = (spur_r == 8'd255) ? spur_r : spur_r + 8'd1;
            last_tgt_s = cur_tgt_r;
            state_s    = IDLE;
         end else begin
            state_s = PRESENT;
         end
      end else begin
         id_s = id_r;
      end

      avalid_s     = 1'b0;
      addr_s       = addr_r;
      wdata_s      = wdata_r;
      wstrb_s      = {(DATA_W/8){1'b0}};
      irq_valid_s  = 1'b0;
      irq_target_s = irq_target_r;
      irq_id_s     = irq_id_r;
      busy_s       = (state_s != IDLE);

      case (state_s)
         RD_REQ: begin
            avalid_s = 1'b1;
            addr_s   = claim_addr(cur_tgt_s);
            wdata_s  = {DATA_W{1'b0}};
         end
         PRESENT: begin
            irq_valid_s  = 1'b1;
            irq_target_s = cur_tgt_s;
            irq_id_s     = id_s;
         end
         WR_REQ: begin
            avalid_s = 1'b1;
            addr_s   = claim_addr(cur_tgt_r);
            wdata_s  = DATA_W'(id_r);
            wstrb_s  = {(DATA_W/8){1'b1}};
         end
         default: begin
            avalid_s = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= IDLE;
         cur_tgt_r    <= {TGT_W{1'b0}};
         last_tgt_r   <= TGT_W'(TARGETS - 1);
         id_r         <= {ID_W{1'b0}};
         spur_r       <= 8'd0;
         avalid_r     <= 1'b0;
         addr_r       <= {ADDR_W{1'b0}};
         wdata_r      <= {DATA_W{1'b0}};
         wstrb_r      <= {(DATA_W/8){1'b0}};
         irq_valid_r  <= 1'b0;
         irq_target_r <= {TGT_W{1'b0}};
         irq_id_r     <= {ID_W{1'b0}};
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         cur_tgt_r    <= cur_tgt_s;
         last_tgt_r   <= last_tgt_s;
         id_r         <= id_s;
         spur_r       <= spur_s;
         avalid_r     <= avalid_s;
         addr_r       <= addr_s;
         wdata_r      <= wdata_s;
         wstrb_r      <= wstrb_s;
         irq_valid_r  <= irq_valid_s;
         irq_target_r <= irq_target_s;
         irq_id_r     <= irq_id_s;
         busy_r       <= busy_s;
      end
   end

   assign iob_avalid   = avalid_r;
   assign iob_addr     = addr_r;
   assign iob_wdata    = wdata_r;
   assign iob_wstrb    = wstrb_r;
   assign irq_valid    = irq_valid_r;
   assign irq_target   = irq_target_r;
   assign irq_id       = irq_id_r;
   assign busy         = busy_r;
   assign spurious_cnt = spur_r;

endmodule

// File: tb/tb_iob_plic_claim_master.sv
// Self-checking bench for iob_plic_claim_master: directed vector table, spurious
// saturation, randomized sequences against a round-robin/counter model, mid-op reset.
module tb_iob_plic_claim_master;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  meip;
   logic        iob_avalid;
   logic [15:0] iob_addr;
   logic [31:0] iob_wdata;
   logic [3:0]  iob_wstrb;
   logic        iob_ready;
   logic        iob_rvalid;
   logic [31:0] iob_rdata;
   logic        irq_valid;
   logic [0:0]  irq_target;
   logic [3:0]  irq_id;
   logic        irq_ready;
   logic        irq_done;
   logic        busy;
   logic [7:0]  spurious_cnt;

   int checks = 0;
   int failures = 0;
   int n_rd = 0;
   int n_wr = 0;
   int model_last = 1;
   int model_spur = 0;

   iob_plic_claim_master dut (
      .clk_i(clk), .rst_i(rst), .meip(meip),
      .iob_avalid(iob_avalid), .iob_addr(iob_addr), .iob_wdata(iob_wdata),
      .iob_wstrb(iob_wstrb), .iob_ready(iob_ready), .iob_rvalid(iob_rvalid),
      .iob_rdata(iob_rdata), .irq_valid(irq_valid), .irq_target(irq_target),
      .irq_id(irq_id), .irq_ready(irq_ready), .irq_done(irq_done),
      .busy(busy), .spurious_cnt(spurious_cnt)
   );

   always #5 clk = ~clk;

   // Bus handshake counters
   always @(posedge clk) begin
      if (!rst && iob_avalid && iob_ready) begin
         if (iob_wstrb != 4'h0) n_wr <= n_wr + 1;
         else n_rd <= n_rd + 1;
      end
   end

   typedef struct {
      logic [1:0]  meip;
      logic [31:0] rdata;
      logic [0:0]  tgt;
      logic [15:0] addr;
      logic [3:0]  id;
      int          rwait;
      bit          same;
      int          irdy;
      bit          stray;
      int          wwait;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int rr_model(input logic [1:0] m);
      for (int i = 1; i <= 2; i++) begin
         int t;
         t = (model_last + i) % 2;
         if (m[t]) return t;
      end
      return model_last;
   endfunction

   // One full claim sequence starting in IDLE; ends back in IDLE.
   task automatic do_seq(input vec_t v, input bit drop);
      int rd0, wr0;
      rd0 = n_rd;
      wr0 = n_wr;
      meip = v.meip;
      tick;
      chk("rd_req", {iob_avalid, iob_wstrb, iob_addr, busy}, {1'b1, 4'h0, v.addr, 1'b1});
      if (drop) meip = 2'b00;
      for (int i = 0; i < v.rwait; i++) begin
         tick;
         chk("rd_hold", {iob_avalid, iob_wstrb, iob_addr}, {1'b1, 4'h0, v.addr});
      end
      iob_ready = 1'b1;
      iob_rvalid = v.same;
      iob_rdata = v.rdata;
      tick;
      iob_ready = 1'b0;
      iob_rvalid = 1'b0;
      if (!v.same) begin
         chk("rd_wait", {iob_avalid, irq_valid}, 2'b00);
         iob_rvalid = 1'b1;
         tick;
         iob_rvalid = 1'b0;
      end
      chk("one_read", n_rd - rd0, 1);
      if (v.id == 4'd0) begin
         model_spur = (model_spur < 255) ? model_spur + 1 : 255;
         chk("spur_idle", {irq_valid, iob_avalid, busy}, 3'b000);
         chk("spur_cnt", spurious_cnt, model_spur);
         chk("spur_no_write", n_wr - wr0, 0);
      end else begin
         chk("present", {irq_valid, irq_target, irq_id, iob_avalid}, {1'b1, v.tgt, v.id, 1'b0});
         if (v.stray) begin
            irq_done = 1'b1;
            tick;
            irq_done = 1'b0;
            chk("stray_done", {irq_valid, iob_avalid}, 2'b10);
         end
         for (int i = 0; i < v.irdy; i++) begin
            tick;
            chk("irq_hold", {irq_valid, irq_target, irq_id}, {1'b1, v.tgt, v.id});
         end
         irq_ready = 1'b1;
         tick;
         irq_ready = 1'b0;
         chk("irq_drop", {irq_valid, busy}, 2'b01);
         tick;
         tick;
         chk("service_quiet", {iob_avalid, 32'(n_wr - wr0)}, 33'd0);
         irq_done = 1'b1;
         tick;
         irq_done = 1'b0;
         chk("wr_req", {iob_avalid, iob_wstrb, iob_addr, iob_wdata},
             {1'b1, 4'hF, v.addr, 28'd0, v.id});
         for (int i = 0; i < v.wwait; i++) begin
            tick;
            chk("wr_hold", {iob_avalid, iob_wstrb, iob_addr, iob_wdata},
                {1'b1, 4'hF, v.addr, 28'd0, v.id});
         end
         iob_ready = 1'b1;
         tick;
         iob_ready = 1'b0;
         chk("wr_done", {iob_avalid, busy}, 2'b00);
         chk("one_write", n_wr - wr0, 1);
      end
      model_last = int'(v.tgt);
   endtask

   initial begin
      vec_t v;
      rst = 1'b1;
      meip = 2'b00;
      iob_ready = 1'b0;
      iob_rvalid = 1'b0;
      iob_rdata = 32'd0;
      irq_ready = 1'b0;
      irq_done = 1'b0;
      tick;
      chk("reset_bus", {iob_avalid, iob_addr, iob_wdata, iob_wstrb}, 53'd0);
      chk("reset_core", {irq_valid, irq_target, irq_id, busy, spurious_cnt}, 15'd0);
      rst = 1'b0;
      tick;

      //         meip   rdata          tgt   addr      id  rw sm ir st ww
      vecs[0] = '{2'b01, 32'd5,         1'b0, 16'h0200, 4'd5, 0, 0, 0, 0, 0};
      vecs[1] = '{2'b11, 32'd7,         1'b1, 16'h0208, 4'd7, 0, 0, 0, 0, 0};
      vecs[2] = '{2'b11, 32'd3,         1'b0, 16'h0200, 4'd3, 0, 0, 0, 0, 0};
      vecs[3] = '{2'b11, 32'd9,         1'b1, 16'h0208, 4'd9, 4, 0, 3, 0, 4};
      vecs[4] = '{2'b10, 32'd0,         1'b1, 16'h0208, 4'd0, 0, 0, 0, 0, 0};
      vecs[5] = '{2'b01, 32'hFFFF_FFF2, 1'b0, 16'h0200, 4'd2, 0, 1, 0, 1, 0};
      vecs[6] = '{2'b11, 32'h0000_0010, 1'b1, 16'h0208, 4'd0, 0, 0, 0, 0, 0};
      vecs[7] = '{2'b01, 32'd8,         1'b0, 16'h0200, 4'd8, 1, 0, 1, 1, 2};
      for (int k = 0; k < 8; k++) do_seq(vecs[k], 1'b0);
      chk("spur_after_table", spurious_cnt, 8'd2);

      v = '{2'b01, 32'd0, 1'b0, 16'h0200, 4'd0, 0, 0, 0, 0, 0};
      for (int k = 0; k < 300; k++) do_seq(v, 1'b0);
      chk("spur_saturated", spurious_cnt, 8'd255);

      for (int k = 0; k < 40; k++) begin
         int t;
         v.meip  = 2'($urandom_range(1, 3));
         v.rdata = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
         t       = rr_model(v.meip);
         v.tgt   = 1'(t);
         v.addr  = 16'h0200 + 16'(t) * 16'h0008;
         v.id    = v.rdata[3:0];
         v.rwait = $urandom_range(0, 3);
         v.same  = 1'($urandom_range(0, 1));
         v.irdy  = $urandom_range(0, 3);
         v.stray = 1'($urandom_range(0, 1));
         v.wwait = $urandom_range(0, 3);
         do_seq(v, 1'($urandom_range(0, 1)));
      end

      meip = 2'b01;
      tick;
      iob_ready = 1'b1;
      tick;
      iob_ready = 1'b0;
      meip = 2'b00;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("midreset_bus", {iob_avalid, iob_addr, iob_wdata, iob_wstrb}, 53'd0);
      chk("midreset_core", {irq_valid, irq_target, irq_id, busy, spurious_cnt}, 15'd0);
      model_last = 1;
      model_spur = 0;
      iob_rvalid = 1'b1;
      iob_rdata = 32'd3;
      tick;
      iob_rvalid = 1'b0;
      chk("stale_rvalid", {irq_valid, busy, iob_avalid}, 3'b000);
      tick;
      chk("stale_rvalid_late", irq_valid, 1'b0);

      v = '{2'b11, 32'd4, 1'b0, 16'h0200, 4'd4, 0, 0, 0, 0, 0};
      do_seq(v, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
